// File: rtl/adc_xy_stream.sv
// ADC X/Y/RGB capture front end: colour/latency alignment, scale/invert, blank/dedup/decimate
// filtering and a small first-word-fall-through FIFO with valid/ready output and drop accounting.
module adc_xy_stream #(
  parameter int DATA_BITS      = 10,
  parameter int OUT_BITS       = 9,
  parameter int ADC_LATENCY    = 7,
  parameter bit X_INVERT       = 1'b1,
  parameter bit Y_INVERT       = 1'b0,
  parameter int FIFO_ADDR_BITS = 2,
  parameter int CNT_BITS       = 16
) (
  input  logic                 adc_clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 dedup_en,
  input  logic                 keep_blank,
  input  logic [7:0]           decim,
  input  logic [DATA_BITS-1:0] adc_x_io,
  input  logic [DATA_BITS-1:0] adc_y_io,
  input  logic                 adc_red_io,
  input  logic                 adc_grn_io,
  input  logic                 adc_blu_io,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [OUT_BITS-1:0]  m_x,
  output logic [OUT_BITS-1:0]  m_y,
  output logic                 m_red,
  output logic                 m_grn,
  output logic                 m_blu,
  output logic [CNT_BITS-1:0]  drop_count,
  output logic                 overflow
);

  localparam int SHIFT     = DATA_BITS - OUT_BITS;
  localparam int DEPTH     = 2 ** FIFO_ADDR_BITS;
  localparam int SAMPLE_W  = 2 * OUT_BITS + 3;
  localparam int WARM_BITS = $clog2(ADC_LATENCY + 2);
  localparam logic [DATA_BITS-1:0] MAX_VAL     = {DATA_BITS{1'b1}};
  localparam logic [WARM_BITS-1:0] WARM_TARGET = WARM_BITS'(ADC_LATENCY + 1);

  logic [OUT_BITS-1:0]       xs_q, xs_d, ys_q, ys_d;
  logic [2:0]                rgb_dly_q [ADC_LATENCY+1];
  logic [2:0]                rgb_dly_d [ADC_LATENCY+1];
  logic [WARM_BITS-1:0]      warm_q, warm_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [SAMPLE_W-1:0]       last_q, last_d;
  logic                      last_valid_q, last_valid_d;
  logic [SAMPLE_W-1:0]       mem_q [DEPTH];
  logic [SAMPLE_W-1:0]       mem_d [DEPTH];
  logic [FIFO_ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_ADDR_BITS:0]   count_q, count_d;
  logic [CNT_BITS-1:0]       drop_q, drop_d;
  logic                      ovf_q, ovf_d;

  logic [DATA_BITS-1:0] x_adj, y_adj;
  logic [SAMPLE_W-1:0]  sample, head;
  logic                 warm_done, lit, dup, full, pop, candidate, push, drop;

  // The colour delay line is one stage longer than the ADC latency because x/y also pass
  // through a register stage before being judged.
  always_comb begin
    x_adj = X_INVERT ? (MAX_VAL - adc_x_io) : adc_x_io;
    y_adj = Y_INVERT ? (MAX_VAL - adc_y_io) : adc_y_io;
    xs_d  = OUT_BITS'(x_adj >> SHIFT);
    ys_d  = OUT_BITS'(y_adj >> SHIFT);
    rgb_dly_d[0] = {adc_red_io, adc_grn_io, adc_blu_io};
    for (int i = 1; i <= ADC_LATENCY; i++) begin
      rgb_dly_d[i] = rgb_dly_q[i-1];
    end
  end

  always_comb begin
    sample    = {xs_q, ys_q, rgb_dly_q[ADC_LATENCY]};
    head      = mem_q[rd_ptr_q];
    warm_done = (warm_q == WARM_TARGET);
    lit       = |rgb_dly_q[ADC_LATENCY];
    dup       = dedup_en && last_valid_q && (sample == last_q);
    full      = count_q[FIFO_ADDR_BITS];
    pop       = (count_q != '0) && m_tready;
    candidate = warm_done && enable && (cnt_q == 8'd0) && (lit || keep_blank) && !dup;
    push      = candidate && (!full || pop);
    drop      = candidate && full && !pop;
  end

  // Next-state for control and FIFO; the synchronous reset overrides everything at the end.
  always_comb begin
    warm_d       = warm_done ? warm_q : warm_q + 1'b1;
    cnt_d        = cnt_q;
    last_d       = last_q;
    last_valid_d = last_valid_q;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    drop_d       = drop_q;
    ovf_d        = ovf_q;

    if (!enable) begin
      cnt_d = 8'd0;
    end else if (cnt_q == 8'd0) begin
      cnt_d = decim;
    end else begin
      cnt_d = cnt_q - 8'd1;
    end

    if (push) begin
      mem_d[wr_ptr_q] = sample;
      wr_ptr_d        = wr_ptr_q + 1'b1;
      last_d          = sample;
      last_valid_d    = 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != '1) begin
        drop_d = drop_q + 1'b1;
      end
    end

    if (reset) begin
      warm_d       = '0;
      cnt_d        = 8'd0;
      last_valid_d = 1'b0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      drop_d       = '0;
      ovf_d        = 1'b0;
    end
  end

  always_ff @(posedge adc_clk) begin
    xs_q         <= xs_d;
    ys_q         <= ys_d;
    rgb_dly_q    <= rgb_dly_d;
    warm_q       <= warm_d;
    cnt_q        <= cnt_d;
    last_q       <= last_d;
    last_valid_q <= last_valid_d;
    mem_q        <= mem_d;
    wr_ptr_q     <= wr_ptr_d;
    rd_ptr_q     <= rd_ptr_d;
    count_q      <= count_d;
    drop_q       <= drop_d;
    ovf_q        <= ovf_d;
  end

  assign m_tvalid   = (count_q != '0);
  assign m_x        = head[SAMPLE_W-1 -: OUT_BITS];
  assign m_y        = head[3 +: OUT_BITS];
  assign m_red      = head[2];
  assign m_grn      = head[1];
  assign m_blu      = head[0];
  assign drop_count = drop_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_adc_xy_stream.sv
// Scoreboarded bench for adc_xy_stream: directed scenarios plus a randomized run, all checked
// against an input-history reference model.
module tb_adc_xy_stream;

  localparam int DATA_BITS = 10;
  localparam int OUT_BITS  = 9;
  localparam int LAT       = 7;
  localparam bit X_INV     = 1'b1;
  localparam bit Y_INV     = 1'b0;
  localparam int ADDR_BITS = 2;
  localparam int CNT_BITS  = 16;
  localparam int DEPTH     = 2 ** ADDR_BITS;
  localparam int SHIFT     = DATA_BITS - OUT_BITS;
  localparam int MAXV      = (1 << DATA_BITS) - 1;
  localparam int HIST      = 4096;

  typedef struct packed {
    logic [OUT_BITS-1:0] x;
    logic [OUT_BITS-1:0] y;
    logic [2:0]          rgb;
  } beat_t;

  logic                 adc_clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 enable = 1'b0, dedup_en = 1'b0, keep_blank = 1'b0;
  logic [7:0]           decim = 8'd0;
  logic [DATA_BITS-1:0] adc_x_io = '0, adc_y_io = '0;
  logic                 adc_red_io = 1'b0, adc_grn_io = 1'b0, adc_blu_io = 1'b0;
  logic                 m_tvalid, m_tready = 1'b0;
  logic [OUT_BITS-1:0]  m_x, m_y;
  logic                 m_red, m_grn, m_blu;
  logic [CNT_BITS-1:0]  drop_count;
  logic                 overflow;

  int checks = 0;
  int errors = 0;
  int beats  = 0;

  adc_xy_stream #(
    .DATA_BITS(DATA_BITS), .OUT_BITS(OUT_BITS), .ADC_LATENCY(LAT), .X_INVERT(X_INV),
    .Y_INVERT(Y_INV), .FIFO_ADDR_BITS(ADDR_BITS), .CNT_BITS(CNT_BITS)
  ) dut (
    .adc_clk(adc_clk), .reset(reset), .enable(enable), .dedup_en(dedup_en),
    .keep_blank(keep_blank), .decim(decim), .adc_x_io(adc_x_io), .adc_y_io(adc_y_io),
    .adc_red_io(adc_red_io), .adc_grn_io(adc_grn_io), .adc_blu_io(adc_blu_io),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_x(m_x), .m_y(m_y), .m_red(m_red),
    .m_grn(m_grn), .m_blu(m_blu), .drop_count(drop_count), .overflow(overflow)
  );

  always #5 adc_clk = ~adc_clk;

  // Reference model state: raw input history plus abstract FIFO occupancy and counters.
  beat_t                exp_q[$];
  logic [DATA_BITS-1:0] hist_x [HIST];
  logic [DATA_BITS-1:0] hist_y [HIST];
  logic [2:0]           hist_rgb [HIST];
  int    edge_no = 0, occ = 0, warm = 0, next_elig = 0, model_drops = 0;
  bit    model_ovf = 1'b0, model_on = 1'b0, last_valid = 1'b0;
  beat_t last_beat;

  function automatic logic [OUT_BITS-1:0] scale(input int raw, input bit inv);
    int v;
    v = inv ? (MAXV - raw) : raw;
    return OUT_BITS'(v >>> SHIFT);
  endfunction

  // A sample judged at edge e carries x/y captured at e-1 and colour captured LAT edges before that.
  always @(posedge adc_clk) begin
    bit    elig, pop, cand;
    beat_t cur;
    hist_x[edge_no % HIST]   = adc_x_io;
    hist_y[edge_no % HIST]   = adc_y_io;
    hist_rgb[edge_no % HIST] = {adc_red_io, adc_grn_io, adc_blu_io};
    if (reset) begin
      exp_q.delete();
      occ = 0; warm = 0; model_drops = 0; model_ovf = 1'b0; last_valid = 1'b0;
      next_elig = edge_no + 1;
      model_on = 1'b1;
    end else if (model_on) begin
      elig = 1'b0;
      if (!enable) next_elig = edge_no + 1;
      else if (edge_no >= next_elig) begin
        elig = 1'b1;
        next_elig = edge_no + int'(decim) + 1;
      end
      cand = 1'b0;
      if (warm >= LAT + 1) begin
        cur.x   = scale(int'(hist_x[(edge_no - 1) % HIST]), X_INV);
        cur.y   = scale(int'(hist_y[(edge_no - 1) % HIST]), Y_INV);
        cur.rgb = hist_rgb[(edge_no - 1 - LAT) % HIST];
        cand = enable && elig && ((cur.rgb != 3'b000) || keep_blank) &&
               !(dedup_en && last_valid && (cur == last_beat));
      end
      pop = (occ > 0) && m_tready;
      if (cand && ((occ < DEPTH) || pop)) begin
        exp_q.push_back(cur);
        occ++;
        last_beat  = cur;
        last_valid = 1'b1;
      end else if (cand) begin
        model_ovf = 1'b1;
        if (model_drops < (1 << CNT_BITS) - 1) model_drops++;
      end
      if (pop) occ--;
      warm++;
    end
    edge_no++;
  end

  // Monitor: compares the presented head against the scoreboard on every handshake.
  always @(negedge adc_clk) begin
    beat_t e;
    if (model_on) begin
      checks++;
      if (m_tvalid !== (exp_q.size() != 0)) begin
        errors++;
        $display("[TB] FAIL m_tvalid @%0t: got %0b expected %0b", $time, m_tvalid, exp_q.size() != 0);
      end
      checks++;
      if (int'(drop_count) != model_drops) begin
        errors++;
        $display("[TB] FAIL drop_count @%0t: got %0d expected %0d", $time, drop_count, model_drops);
      end
      checks++;
      if (overflow !== model_ovf) begin
        errors++;
        $display("[TB] FAIL overflow @%0t: got %0b expected %0b", $time, overflow, model_ovf);
      end
      if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
        beats++;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checks++;
          if ({m_x, m_y, m_red, m_grn, m_blu} !== e) begin
            errors++;
            $display("[TB] FAIL beat @%0t: got x=%0h y=%0h rgb=%0b%0b%0b expected x=%0h y=%0h rgb=%03b",
                     $time, m_x, m_y, m_red, m_grn, m_blu, e.x, e.y, e.rgb);
          end
        end
      end
    end
  end

  task automatic apply_stimulus(input logic rst, input logic en, input logic ded, input logic kb,
                                input logic [7:0] dc, input int x, input int y,
                                input logic [2:0] rgb, input logic rdy);
    reset = rst; enable = en; dedup_en = ded; keep_blank = kb; decim = dc;
    adc_x_io = DATA_BITS'(x); adc_y_io = DATA_BITS'(y);
    {adc_red_io, adc_grn_io, adc_blu_io} = rgb;
    m_tready = rdy;
    @(posedge adc_clk);
    #1;
  endtask

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  initial begin
    int base;
    $display("[TB] start");

    // Constant lit sample with dedup: exactly one beat (x inverted to 0, y scaled to 0x100).
    repeat (2) apply_stimulus(1, 1, 1, 0, 0, 'h3FF, 'h200, 3'b100, 1);
    base = beats;
    repeat (30) apply_stimulus(0, 1, 1, 0, 0, 'h3FF, 'h200, 3'b100, 1);
    check_output("dedup_single_beat", beats - base, 1);

    // Ten distinct lit samples into a stalled depth-4 FIFO: four held, six dropped.
    repeat (2) apply_stimulus(1, 1, 0, 0, 0, 0, 0, 3'b000, 0);
    for (int i = 0; i < 40; i++) begin
      logic [2:0] c;
      c = (i >= LAT + 3 && i < LAT + 13) ? 3'(i % 7 + 1) : 3'b000;
      apply_stimulus(0, 1, 0, 0, 0, i * 3, i, c, 0);
    end
    check_output("stall_drop_count", int'(drop_count), 6);
    check_output("stall_overflow", int'(overflow), 1);
    check_output("stall_valid", int'(m_tvalid), 1);
    base = beats;
    repeat (10) apply_stimulus(0, 1, 0, 0, 0, 5, 5, 3'b000, 1);
    check_output("stall_drain_beats", beats - base, 4);
    check_output("overflow_sticky", int'(overflow), 1);

    // Fill again, then a single reset cycle must clear valid and the counters.
    for (int i = 0; i < 15; i++) apply_stimulus(0, 1, 0, 0, 0, 100 + i * 2, 7, 3'b010, 0);
    check_output("full_before_reset", int'(m_tvalid), 1);
    apply_stimulus(1, 1, 0, 0, 0, 0, 0, 3'b010, 0);
    check_output("reset_valid", int'(m_tvalid), 0);
    check_output("reset_drop_count", int'(drop_count), 0);
    check_output("reset_overflow", int'(overflow), 0);

    // Decimation by 4 on an x ramp: one beat every fourth cycle.
    for (int i = 0; i < 12; i++) apply_stimulus(0, 1, 0, 0, 3, i, 9, 3'b111, 1);
    base = beats;
    for (int i = 12; i < 52; i++) apply_stimulus(0, 1, 0, 0, 3, i, 9, 3'b111, 1);
    check_output("decim_beats", beats - base, 10);

    // Blank samples: suppressed unless keep_blank.
    for (int i = 0; i < 20; i++) apply_stimulus(0, 1, 0, 0, 0, i, 1, 3'b000, 1);
    base = beats;
    for (int i = 0; i < 20; i++) apply_stimulus(0, 1, 0, 0, 0, i, 1, 3'b000, 1);
    check_output("blank_suppressed", beats - base, 0);
    base = beats;
    for (int i = 0; i < 20; i++) apply_stimulus(0, 1, 0, 1, 0, i, 1, 3'b000, 1);
    check_output("blank_kept", int'((beats - base) >= 15), 1);

    // Randomized traffic with occasional mid-stream resets.
    for (int i = 0; i < 1500; i++) begin
      int x, y;
      logic [2:0] c;
      logic [7:0] d;
      x = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3) << 8) : int'($urandom_range(0, MAXV));
      y = ($urandom_range(0, 1) == 0) ? 'h155 : int'($urandom_range(0, MAXV));
      c = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
      d = ($urandom_range(0, 9) < 7) ? 8'd0 : 8'($urandom_range(1, 3));
      apply_stimulus($urandom_range(0, 399) == 0, $urandom_range(0, 19) != 0,
                     $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, d, x, y, c,
                     $urandom_range(0, 9) < 6);
    end
    repeat (20) apply_stimulus(0, 0, 0, 0, 0, 0, 0, 3'b000, 1);
    check_output("final_scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
